// File: rtl/std_regslice_pkg.sv
// Shared state encoding for the valid/ready register slice.
// Occupancy is read straight off the state register.
package std_regslice_pkg;

   typedef enum logic [1:0] {
      REGSLICE_EMPTY = 2'd0,
      REGSLICE_ONE   = 2'd1,
      REGSLICE_FULL  = 2'd2
   } regslice_state_e;

endpackage

// File: rtl/std_dffern.sv
// Enabled D flip-flop bank with synchronous active-low reset.
// Reset value is a parameter so the same cell serves data and control.
module std_dffern #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!resetn)
         q <= RESET_VALUE;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/std_regslice_vr.sv
// Valid/ready register slice: 2-entry skid buffer, all outputs registered.
// Cuts forward and backward combinational paths at full throughput.
module std_regslice_vr
   import std_regslice_pkg::*;
#(
   parameter int                    DATA_WIDTH       = 32,
   parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            occupancy
);

   regslice_state_e       state;
   regslice_state_e       next_state;
   logic                  s_fire;
   logic                  m_fire;
   logic                  main_en;
   logic                  skid_en;
   logic [DATA_WIDTH-1:0] main_d;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;

   assign s_fire    = s_valid & s_ready;
   assign m_fire    = m_valid & m_ready;
   assign m_valid   = (state != REGSLICE_EMPTY);
   assign occupancy = state;
   assign m_data    = main_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= REGSLICE_EMPTY;
         s_ready <= 1'b0;
      end else begin
         state   <= next_state;
         s_ready <= (next_state != REGSLICE_FULL);
      end
   end

   always_comb begin
      next_state = state;
      main_en    = 1'b0;
      skid_en    = 1'b0;
      main_d     = s_data;
      unique case (state)
         REGSLICE_EMPTY: begin
            if (s_fire) begin
               next_state = REGSLICE_ONE;
               main_en    = 1'b1;
            end
         end
         REGSLICE_ONE: begin
            if (s_fire && m_fire) begin
               main_en = 1'b1;
            end else if (s_fire) begin
               next_state = REGSLICE_FULL;
               skid_en    = 1'b1;
            end else if (m_fire) begin
               next_state = REGSLICE_EMPTY;
            end
         end
         REGSLICE_FULL: begin
            if (m_fire) begin
               next_state = REGSLICE_ONE;
               main_en    = 1'b1;
               main_d     = skid_q;
            end
         end
         default: next_state = REGSLICE_EMPTY;
      endcase
      // flush discards everything, including a beat accepted this cycle
      if (flush) begin
         next_state = REGSLICE_EMPTY;
         main_en    = 1'b0;
         skid_en    = 1'b0;
      end
   end

   std_dffern #(
      .WIDTH       (DATA_WIDTH),
      .RESET_VALUE (DATA_RESET_VALUE)
   ) u_main (
      .clk    (clk),
      .resetn (resetn),
      .en     (main_en),
      .d      (main_d),
      .q      (main_q)
   );

   std_dffern #(
      .WIDTH       (DATA_WIDTH),
      .RESET_VALUE (DATA_RESET_VALUE)
   ) u_skid (
      .clk    (clk),
      .resetn (resetn),
      .en     (skid_en),
      .d      (s_data),
      .q      (skid_q)
   );

endmodule

// File: tb/tb_std_regslice_vr.sv
// Bench for std_regslice_vr: directed steps plus random traffic
// compared against a queue-based model of the slice.
module tb_std_regslice_vr;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q[$];
   logic        exp_srdy = 1'b0;

   always #5 clk = ~clk;

   std_regslice_vr #(
      .DATA_WIDTH       (32),
      .DATA_RESET_VALUE (32'h0)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .occupancy (occupancy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic sf;
      logic mf;
      if (!resetn) begin
         q.delete();
         exp_srdy = 1'b0;
      end else if (flush) begin
         q.delete();
         exp_srdy = 1'b1;
      end else begin
         sf = s_valid && exp_srdy;
         mf = (q.size() != 0) && m_ready;
         if (mf) void'(q.pop_front());
         if (sf) q.push_back(s_data);
         exp_srdy = (q.size() != 2);
      end
   endtask

   task automatic model_check();
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(exp_srdy));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      if (q.size() != 0) chk("m_data", m_data, q[0]);
   endtask

   task automatic step(input logic sv, input logic mr,
                       input logic [31:0] sd, input logic fl,
                       input logic rn);
      s_valid = sv;
      m_ready = mr;
      s_data  = sd;
      flush   = fl;
      resetn  = rn;
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   initial begin
      resetn  = 1'b0;
      flush   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_data  = '0;

      // reset held 3 cycles, even with traffic offered
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0);
         chk("rst_m_valid", 32'(m_valid), 32'd0);
         chk("rst_s_ready", 32'(s_ready), 32'd0);
         chk("rst_occ", 32'(occupancy), 32'd0);
         chk("rst_m_data", m_data, 32'h0);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("rel_s_ready", 32'(s_ready), 32'd1);

      // streaming 1..8
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b1, 32'(i), 1'b0, 1'b1);
         chk("stream_data", m_data, 32'(i));
         chk("stream_occ", 32'(occupancy), 32'd1);
      end
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      chk("stream_drain", 32'(m_valid), 32'd0);

      // backpressure
      step(1'b1, 1'b0, 32'hA, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'hB, 1'b0, 1'b1);
      chk("bp_occ", 32'(occupancy), 32'd2);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_data", m_data, 32'hA);
      step(1'b1, 1'b0, 32'hC, 1'b0, 1'b1);
      chk("bp_hold", m_data, 32'hA);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      chk("bp_pop1", m_data, 32'hB);
      chk("bp_ready", 32'(s_ready), 32'd1);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      chk("bp_empty", 32'(m_valid), 32'd0);

      // flush while FULL with s_valid high
      step(1'b1, 1'b0, 32'hA, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'hB, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'hC, 1'b1, 1'b1);
      chk("fl_m_valid", 32'(m_valid), 32'd0);
      chk("fl_occ", 32'(occupancy), 32'd0);
      chk("fl_s_ready", 32'(s_ready), 32'd1);
      step(1'b1, 1'b0, 32'h11, 1'b0, 1'b1);
      chk("fl_after", m_data, 32'h11);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      chk("fl_no_old", 32'(m_valid), 32'd0);

      // simultaneous in/out while ONE
      step(1'b1, 1'b0, 32'h21, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h22, 1'b0, 1'b1);
      chk("sim_occ", 32'(occupancy), 32'd1);
      chk("sim_data", m_data, 32'h22);

      // random traffic with occasional flush
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, ($urandom_range(0, 63) == 0), 1'b1);
      end

      // mid-reset while FULL
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 32'h31, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h32, 1'b0, 1'b1);
      chk("mr_full", 32'(occupancy), 32'd2);
      step(1'b1, 1'b1, 32'h33, 1'b1, 1'b0);
      chk("mr_m_valid", 32'(m_valid), 32'd0);
      chk("mr_s_ready", 32'(s_ready), 32'd0);
      chk("mr_occ", 32'(occupancy), 32'd0);
      chk("mr_m_data", m_data, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("mr_rel", 32'(s_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
